mmu_bus_req_scheduler: RTL and testbench
========================================

# mmu_bus_req_scheduler

Registered arbiter and sequencer for the external bus-cycle request path. It merges the core data-read, data-write and opcode-miss requests, the MMU table-walk read and the two background burst-prefetch requests into one bus request. Core sources are gated by the MMU runtime fault and stall indications, and arbitration is fixed-priority with a prefetch anti-starvation counter. It sits between the core and MMU request logic and the bus interface unit, and holds each grant until the bus unit signals cycle completion.

## Interface
- PF_MAX_WAIT, 8: consecutive lost arbitrations after which a pending prefetch is promoted (1..255).
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_rd_bus  in  1  core data-read request (level).
- data_wr  in  1  core data-write request (level).
- opcode_req_core_miss  in  1  core opcode-fetch miss request (level).
- mmu_tw_req  in  1  MMU table-walk descriptor read request (level).
- burst_prefetch_data_req  in  1  background data burst prefetch request.
- burst_prefetch_op_req  in  1  background opcode burst prefetch request.
- mmu_runtime_fault  in  1  MMU fault; masks core sources.
- mmu_runtime_stall  in  1  MMU table-search window; masks core sources.
- core_lock  in  1  core requests an indivisible RMW sequence (TAS/CAS).
- bus_done  in  1  bus unit: current cycle terminated (ack or error), one-cycle pulse.
- bus_req  out  1  a bus cycle is requested/owned; reset 0.
- bus_wr  out  1  granted cycle is a write; reset 0.
- bus_lock  out  1  locked RMW sequence in progress; reset 0.
- grant  out  6  one-hot owner: [0] rd, [1] wr, [2] op, [3] tw, [4] pf_data, [5] pf_op; reset 0.
- done  out  6  grant & bus_done, combinational; one-cycle completion pulse per source.

## Operation
- FSM states: IDLE, BUSY. Reset → IDLE, grant = 0, bus_req = 0, bus_lock = 0, age = 0.
- Eligibility in IDLE:
  - Core rd, wr and op are eligible only if !mmu_runtime_fault && !mmu_runtime_stall.
  - tw and the prefetch sources are never masked.
- Priority: tw > wr > rd > op > pf_data > pf_op.
- Promotion: if age == PF_MAX_WAIT and a prefetch is eligible, prefetch ranks above rd and op but still below tw and wr. pf_data still precedes pf_op.
- IDLE with at least one eligible source: register a one-hot grant, set bus_wr = grant[1], go to BUSY.
- IDLE with no eligible source: stay in IDLE; outputs stay 0.
- BUSY: grant, bus_req and bus_wr are held constant and input changes are ignored. A fault or stall that rises mid-cycle does not abort the cycle.
- On bus_done in BUSY: clear grant, bus_req and bus_wr, and return to IDLE.
- Age counter (width ceil(log2(PF_MAX_WAIT+1))):
  - Increments, saturating at PF_MAX_WAIT, on each IDLE grant to a non-prefetch source while a prefetch request is pending.
  - Clears when either prefetch is granted.
  - Otherwise holds.
- Lock:
  - bus_lock sets when rd or wr is granted with core_lock = 1.
  - While bus_lock = 1, only rd and wr (still masked by fault/stall) are eligible; tw, op and prefetch are blocked.
  - bus_lock clears in IDLE when core_lock = 0.
- A simultaneous bus_done and new request does not shorten turnaround; the request is arbitrated in the following IDLE cycle.
- Reset asserted in BUSY forces IDLE immediately; done is 0 while reset is asserted.

## Timing
- Request sampled in IDLE at cycle N → grant and bus_req visible at N+1.
- bus_done at cycle M → done pulse at M (combinational), grant low at M+1 (IDLE), next grant at M+2 at the earliest.
- Minimum spacing is 1 idle cycle between bus cycles; throughput is one cycle per (bus length + 1).
- Invariant: grant is zero or one-hot.
- Invariant: bus_req == |grant.
- Invariant: a core grant bit never rises in a cycle following an IDLE cycle in which mmu_runtime_fault or mmu_runtime_stall was 1.
- Invariant: while bus_lock = 1, grant[2..5] never rises.

## Test plan
- Reset check: assert reset for 2 cycles during BUSY → grant = 0, bus_req = 0, bus_lock = 0, age = 0 on the cycle after.
- Stall masking: data_rd_bus, data_wr, opcode_req_core_miss and burst_prefetch_data_req all 1 with mmu_runtime_stall = 1 → grant = 6'b010000.
- Release order after stall: drop stall, then bus_done each cycle → grants in order wr (000010), rd (000001), op (000100).
- Table-walk priority: mmu_tw_req = 1 and data_wr = 1 together → grant = 001000 first; wr granted 2 cycles after the bus_done.
- Starvation with PF_MAX_WAIT = 2:
  - Continuous data_rd_bus with burst_prefetch_op_req = 1 → rd, rd, then pf_op (100000).
  - age reads 0 after the pf_op grant.
- Locked RMW:
  - data_rd_bus with core_lock = 1, then data_wr, while tw and pf requests are held.
  - → rd then wr granted with bus_lock = 1 throughout.
  - tw granted only after core_lock = 0.
- Mid-cycle fault: assert mmu_runtime_fault while rd is in BUSY → grant holds until bus_done and the done[0] pulse fires.

Source files
------------

// File: rtl/mmu_bus_req_scheduler_if.sv
// Bus-request path between core/MMU request sources and the bus interface unit.
// Handshake: bus_req/grant stay constant once raised; the owner is released only by a one-cycle bus_done pulse.
interface mmu_bus_req_scheduler_if;
    logic       data_rd_bus;
    logic       data_wr;
    logic       opcode_req_core_miss;
    logic       mmu_tw_req;
    logic       burst_prefetch_data_req;
    logic       burst_prefetch_op_req;
    logic       mmu_runtime_fault;
    logic       mmu_runtime_stall;
    logic       core_lock;
    logic       bus_done;
    logic       bus_req;
    logic       bus_wr;
    logic       bus_lock;
    logic [5:0] grant;
    logic [5:0] done;

    modport slave (
        input  data_rd_bus, data_wr, opcode_req_core_miss, mmu_tw_req,
               burst_prefetch_data_req, burst_prefetch_op_req,
               mmu_runtime_fault, mmu_runtime_stall, core_lock, bus_done,
        output bus_req, bus_wr, bus_lock, grant, done
    );

    modport master (
        output data_rd_bus, data_wr, opcode_req_core_miss, mmu_tw_req,
               burst_prefetch_data_req, burst_prefetch_op_req,
               mmu_runtime_fault, mmu_runtime_stall, core_lock, bus_done,
        input  bus_req, bus_wr, bus_lock, grant, done
    );
endinterface

// File: rtl/mmu_bus_req_scheduler.sv
// Fixed-priority registered arbiter for the external bus request, with MMU masking,
// locked RMW sequencing and a prefetch anti-starvation age counter.
module mmu_bus_req_scheduler #(
    parameter int PF_MAX_WAIT = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    mmu_bus_req_scheduler_if.slave             bus,
    output logic                               state_dbg,
    output logic [$clog2(PF_MAX_WAIT+1)-1:0]   age_dbg
);
    localparam int AGE_W = $clog2(PF_MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(PF_MAX_WAIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [AGE_W-1:0] age;
    logic [5:0]       elig;
    logic [5:0]       next_grant;
    logic             core_ok;
    logic             promote;
    logic             pf_pending;

    always_comb begin
        core_ok    = !bus.mmu_runtime_fault && !bus.mmu_runtime_stall;
        pf_pending = bus.burst_prefetch_data_req || bus.burst_prefetch_op_req;
        // A held lock admits only the rd/wr halves of the RMW sequence.
        elig[0] = bus.data_rd_bus && core_ok;
        elig[1] = bus.data_wr && core_ok;
        elig[2] = bus.opcode_req_core_miss && core_ok && !bus.bus_lock;
        elig[3] = bus.mmu_tw_req && !bus.bus_lock;
        elig[4] = bus.burst_prefetch_data_req && !bus.bus_lock;
        elig[5] = bus.burst_prefetch_op_req && !bus.bus_lock;
        promote = (age == AGE_MAX) && (elig[4] || elig[5]);
    end

    always_comb begin
        next_grant = 6'b000000;
        if (elig[3])                 next_grant = 6'b001000;
        else if (elig[1])            next_grant = 6'b000010;
        else if (promote && elig[4]) next_grant = 6'b010000;
        else if (promote && elig[5]) next_grant = 6'b100000;
        else if (elig[0])            next_grant = 6'b000001;
        else if (elig[2])            next_grant = 6'b000100;
        else if (elig[4])            next_grant = 6'b010000;
        else if (elig[5])            next_grant = 6'b100000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.grant    <= 6'b000000;
            bus.bus_req  <= 1'b0;
            bus.bus_wr   <= 1'b0;
            bus.bus_lock <= 1'b0;
            age          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|next_grant) begin
                        state       <= BUSY;
                        bus.grant   <= next_grant;
                        bus.bus_req <= 1'b1;
                        bus.bus_wr  <= next_grant[1];
                        if (next_grant[4] || next_grant[5])
                            age <= '0;
                        else if (pf_pending && (age != AGE_MAX))
                            age <= age + 1'b1;
                        if (next_grant[0] || next_grant[1])
                            bus.bus_lock <= bus.core_lock;
                        else if (!bus.core_lock)
                            bus.bus_lock <= 1'b0;
                    end else if (!bus.core_lock) begin
                        bus.bus_lock <= 1'b0;
                    end
                end
                BUSY: begin
                    // Fault/stall arriving here cannot abort the cycle already on the bus.
                    if (bus.bus_done) begin
                        state       <= IDLE;
                        bus.grant   <= 6'b000000;
                        bus.bus_req <= 1'b0;
                        bus.bus_wr  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.done  = bus.grant & {6{bus.bus_done && !reset}};
    assign state_dbg = (state == BUSY);
    assign age_dbg   = age;
endmodule

// File: tb/tb_mmu_bus_req_scheduler.sv
// Bench for mmu_bus_req_scheduler: directed scenarios plus randomized traffic against
// a rule-level reference model with an expected-grant queue.
module tb_mmu_bus_req_scheduler;
  localparam int PF_MAX = 2;
  localparam int AW = $clog2(PF_MAX + 1);

  logic clk;
  logic reset;
  logic state_dbg;
  logic [AW-1:0] age_dbg;
  mmu_bus_req_scheduler_if bus_if ();

  mmu_bus_req_scheduler #(.PF_MAX_WAIT(PF_MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave), .state_dbg(state_dbg), .age_dbg(age_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit rd, input bit wr, input bit op, input bit tw, input bit pfd, input bit pfo);
    bus_if.data_rd_bus = rd;
    bus_if.data_wr = wr;
    bus_if.opcode_req_core_miss = op;
    bus_if.mmu_tw_req = tw;
    bus_if.burst_prefetch_data_req = pfd;
    bus_if.burst_prefetch_op_req = pfo;
  endtask

  task automatic chk_grant(input string name, input logic [5:0] exp);
    chk(name, 32'(bus_if.grant), 32'(exp));
  endtask

  // reference model: ownership, lock and age derived from the arbitration rules
  logic [5:0] m_grant = '0;
  bit m_lock = 0;
  int m_age = 0;
  int order_norm[6] = '{3, 1, 0, 2, 4, 5};
  int order_prom[6] = '{3, 1, 4, 5, 0, 2};

  always @(posedge clk) begin
    bit el[6];
    bit core_ok;
    bit promote;
    int pick;
    int idx;
    if (reset) begin
      m_grant = '0;
      m_lock = 0;
      m_age = 0;
    end else if (m_grant != 0) begin
      if (bus_if.bus_done) m_grant = '0;
    end else begin
      core_ok = !bus_if.mmu_runtime_fault && !bus_if.mmu_runtime_stall;
      el[0] = bus_if.data_rd_bus && core_ok;
      el[1] = bus_if.data_wr && core_ok;
      el[2] = bus_if.opcode_req_core_miss && core_ok && !m_lock;
      el[3] = bus_if.mmu_tw_req && !m_lock;
      el[4] = bus_if.burst_prefetch_data_req && !m_lock;
      el[5] = bus_if.burst_prefetch_op_req && !m_lock;
      promote = (m_age == PF_MAX) && (el[4] || el[5]);
      pick = -1;
      for (int k = 0; k < 6; k++) begin
        idx = promote ? order_prom[k] : order_norm[k];
        if (pick < 0 && el[idx]) pick = idx;
      end
      if (pick >= 0) begin
        m_grant = 6'(1 << pick);
        exp_q.push_back(m_grant);
        if (pick >= 4) m_age = 0;
        else if (bus_if.burst_prefetch_data_req || bus_if.burst_prefetch_op_req)
          m_age = (m_age + 1 > PF_MAX) ? PF_MAX : m_age + 1;
      end
      if (pick == 0 || pick == 1) m_lock = bus_if.core_lock;
      else if (!bus_if.core_lock) m_lock = 0;
    end
  end

  // monitor / scoreboard
  logic [5:0] prev_grant = '0;
  always @(negedge clk) begin
    logic [5:0] e;
    if (mon_en) begin
      chk("grant", 32'(bus_if.grant), 32'(m_grant));
      chk("bus_req", 32'(bus_if.bus_req), 32'(m_grant != 0));
      chk("bus_wr", 32'(bus_if.bus_wr), 32'(m_grant[1]));
      chk("bus_lock", 32'(bus_if.bus_lock), 32'(m_lock));
      chk("age", 32'(age_dbg), 32'(m_age));
      chk("state", 32'(state_dbg), 32'(m_grant != 0));
      chk("done", 32'(bus_if.done), 32'(m_grant & {6{bus_if.bus_done && !reset}}));
      if (bus_if.grant != 0 && prev_grant == 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(bus_if.grant), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_grant", 32'(bus_if.grant), 32'(e));
        end
      end
      prev_grant = bus_if.grant;
    end
  end

  initial begin
    reset = 1;
    set_req(0, 0, 0, 0, 0, 0);
    bus_if.mmu_runtime_fault = 0;
    bus_if.mmu_runtime_stall = 0;
    bus_if.core_lock = 0;
    bus_if.bus_done = 0;
    tick();
    tick();
    reset = 0;
    mon_en = 1;
    chk_grant("rst_grant", 6'b000000);
    chk("rst_bus_req", 32'(bus_if.bus_req), 0);

    // stall masking, then release order
    set_req(1, 1, 1, 0, 1, 0);
    bus_if.mmu_runtime_stall = 1;
    tick();
    chk_grant("stall_mask", 6'b010000);
    bus_if.burst_prefetch_data_req = 0;
    bus_if.mmu_runtime_stall = 0;
    bus_if.bus_done = 1;
    tick();
    chk_grant("rel_idle0", 6'b000000);
    tick();
    chk_grant("rel_wr", 6'b000010);
    chk("rel_bus_wr", 32'(bus_if.bus_wr), 1);
    bus_if.data_wr = 0;
    tick();
    tick();
    chk_grant("rel_rd", 6'b000001);
    bus_if.data_rd_bus = 0;
    tick();
    tick();
    chk_grant("rel_op", 6'b000100);
    bus_if.opcode_req_core_miss = 0;
    tick();
    bus_if.bus_done = 0;

    // table walk beats write
    set_req(0, 1, 0, 1, 0, 0);
    tick();
    chk_grant("tw_first", 6'b001000);
    bus_if.mmu_tw_req = 0;
    bus_if.bus_done = 1;
    #1;
    chk("tw_done", 32'(bus_if.done), 32'(6'b001000));
    tick();
    chk_grant("tw_idle", 6'b000000);
    tick();
    chk_grant("tw_then_wr", 6'b000010);
    bus_if.data_wr = 0;
    tick();

    // prefetch starvation promotion
    set_req(1, 0, 0, 0, 0, 1);
    tick();
    chk_grant("starve_rd1", 6'b000001);
    tick();
    tick();
    chk_grant("starve_rd2", 6'b000001);
    tick();
    tick();
    chk_grant("starve_pfop", 6'b100000);
    chk("starve_age0", 32'(age_dbg), 0);
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    bus_if.bus_done = 0;

    // locked RMW
    set_req(1, 0, 0, 0, 0, 0);
    bus_if.core_lock = 1;
    tick();
    chk_grant("lock_rd", 6'b000001);
    chk("lock_set", 32'(bus_if.bus_lock), 1);
    set_req(0, 1, 0, 1, 1, 0);
    bus_if.bus_done = 1;
    tick();
    tick();
    chk_grant("lock_wr", 6'b000010);
    chk("lock_held", 32'(bus_if.bus_lock), 1);
    bus_if.data_wr = 0;
    tick();
    tick();
    chk_grant("lock_blocks_tw", 6'b000000);
    bus_if.core_lock = 0;
    tick();
    chk("lock_clear", 32'(bus_if.bus_lock), 0);
    tick();
    chk_grant("tw_after_unlock", 6'b001000);
    set_req(0, 0, 0, 0, 0, 0);
    tick();
    bus_if.bus_done = 0;

    // reset in BUSY
    bus_if.data_wr = 1;
    tick();
    chk_grant("pre_rst_wr", 6'b000010);
    reset = 1;
    bus_if.bus_done = 1;
    #1;
    chk("rst_done_low", 32'(bus_if.done), 0);
    tick();
    tick();
    reset = 0;
    bus_if.data_wr = 0;
    bus_if.bus_done = 0;
    chk_grant("rst_busy_grant", 6'b000000);
    chk("rst_busy_lock", 32'(bus_if.bus_lock), 0);
    chk("rst_busy_age", 32'(age_dbg), 0);

    // mid-cycle fault
    bus_if.data_rd_bus = 1;
    tick();
    bus_if.mmu_runtime_fault = 1;
    bus_if.data_rd_bus = 0;
    tick();
    tick();
    chk_grant("fault_hold", 6'b000001);
    bus_if.bus_done = 1;
    #1;
    chk("fault_done", 32'(bus_if.done), 32'(6'b000001));
    tick();
    chk_grant("fault_release", 6'b000000);
    bus_if.bus_done = 0;
    bus_if.mmu_runtime_fault = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_req($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      bus_if.mmu_runtime_fault = ($urandom_range(0, 9) == 0);
      bus_if.mmu_runtime_stall = ($urandom_range(0, 7) == 0);
      bus_if.core_lock = ($urandom_range(0, 3) == 0);
      bus_if.bus_done = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    reset = 0;
    set_req(0, 0, 0, 0, 0, 0);
    bus_if.core_lock = 0;
    bus_if.mmu_runtime_fault = 0;
    bus_if.mmu_runtime_stall = 0;
    bus_if.bus_done = 1;
    tick();
    tick();
    tick();
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
